// File: rtl/memacc_pkg.sv
// Shared types and access-size helpers for the data-memory access stage.
// Optional byte-enable write path is selected with MEMACC_BYTE_EN_EN.
package memacc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] func3);
    logic [3:0] n;
    case (func3[1:0])
      2'd0:    n = 4'd1;
      2'd1:    n = 4'd2;
      2'd2:    n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic misaligned(input logic [2:0] func3, input logic [2:0] offset);
    logic m;
    case (func3[1:0])
      2'd1:    m = offset[0];
      2'd2:    m = |offset[1:0];
      2'd3:    m = |offset;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Byte mask of the lane touched by an access, little-endian from offset.
  function automatic logic [7:0] lane_mask(input logic [2:0] func3, input logic [2:0] offset);
    logic [15:0] m;
    m = (16'd1 << size_bytes(func3)) - 16'd1;
    return m[7:0] << offset;
  endfunction

  function automatic logic access_error(input logic we, input logic [2:0] func3,
                                        input logic [2:0] offset);
    return (func3 == 3'b111) || (we && func3[2]) || misaligned(func3, offset);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Combinational load lane extraction with sign/zero extension; kept separate so a
// load-forwarding path can share it.
module load_extract
  import memacc_pkg::*;
(
  input  logic [63:0] mdr,
  input  logic [2:0]  offset,
  input  logic [2:0]  func3,
  output logic [63:0] data
);

  logic [63:0] lane;

  always_comb begin
    lane = mdr >> {offset, 3'b000};
    data = '0;
    case (func3)
      F3_B:    data = {{56{lane[7]}}, lane[7:0]};
      F3_H:    data = {{48{lane[15]}}, lane[15:0]};
      F3_W:    data = {{32{lane[31]}}, lane[31:0]};
      F3_D:    data = lane;
      F3_BU:   data = {56'd0, lane[7:0]};
      F3_HU:   data = {48'd0, lane[15:0]};
      F3_WU:   data = {32'd0, lane[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access stage: lane extraction, read-modify-write for narrow stores,
// misalignment errors. Define MEMACC_BYTE_EN_EN to write narrow stores with mem_be.
// Handshake: a request is taken on a rising edge where req_valid && req_ready; req_ready
// is high only in IDLE, and rsp_valid pulses for one cycle when the access completes.
module mem_access_unit
  import memacc_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int DATA_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [63:0]       mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEMACC_BYTE_EN_EN
  ,
  output logic [7:0]        mem_be
`endif
);

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic [1:0]  cnt;
  logic [63:0] ext_data;
  logic [63:0] lane_wdata;
  logic [63:0] merge_data;
  logic [7:0]  be_mask;

  // mem_rdata is valid during DATA, so it serves directly as the MDR value.
  load_extract u_extract (
    .mdr    (mem_rdata),
    .offset (off_q),
    .func3  (f3_q),
    .data   (ext_data)
  );

  always_comb begin
    lane_wdata = wdata_q << {off_q, 3'b000};
    be_mask    = lane_mask(f3_q, off_q);
    merge_data = '0;
    for (int i = 0; i < 8; i++) begin
      merge_data[8*i +: 8] = be_mask[i] ? lane_wdata[8*i +: 8] : mem_rdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
`ifdef MEMACC_BYTE_EN_EN
      mem_be    <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      mem_wr    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            f3_q      <= req_func3;
            off_q     <= req_addr[2:0];
            wdata_q   <= req_wdata;
            mem_addr  <= {req_addr[63:3], 3'b000};
            req_ready <= 1'b0;
            cnt       <= 2'(MEM_RD_LAT - 1);
            if (access_error(req_we, req_func3, req_addr[2:0])) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && req_func3 == F3_D) begin
              state     <= S_WRITE;
              mem_wr    <= 1'b1;
              mem_wdata <= req_wdata;
`ifdef MEMACC_BYTE_EN_EN
              mem_be    <= 8'hFF;
`endif
            end
`ifdef MEMACC_BYTE_EN_EN
            else if (req_we) begin
              state     <= S_WRITE;
              mem_wr    <= 1'b1;
              mem_wdata <= req_wdata << {req_addr[2:0], 3'b000};
              mem_be    <= lane_mask(req_func3, req_addr[2:0]);
            end
`endif
            else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (cnt == 2'd0) state <= S_DATA;
          else             cnt   <= cnt - 2'd1;
        end
        S_DATA: begin
          if (we_q) begin
            state     <= S_WRITE;
            mem_wr    <= 1'b1;
            mem_wdata <= merge_data;
`ifdef MEMACC_BYTE_EN_EN
            mem_be    <= 8'hFF;
`endif
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= ext_data;
          end
        end
        S_WRITE: begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
`ifdef MEMACC_BYTE_EN_EN
          mem_be    <= '0;
`endif
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed plan cases, then random traffic checked
// against a byte-level reference memory.
module tb_mem_access_unit;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [63:0] rsp_rdata;
  logic [63:0] mem_addr;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
`ifdef MEMACC_BYTE_EN_EN
  logic [7:0]  mem_be;
`endif

  mem_access_unit #(.MEM_RD_LAT(RD_LAT), .DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MEMACC_BYTE_EN_EN
    ,
    .mem_be    (mem_be)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // data memory model: 16 doublewords, read latency RD_LAT
  logic [63:0] dmem [0:15];
  logic [63:0] init_w [0:15];
  logic [63:0] rd_pipe [0:RD_LAT-1];
  logic        load_mem = 1'b0;
  int          wr_count = 0;
  assign mem_rdata = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    rd_pipe[0] <= dmem[mem_addr[6:3]];
    for (int s = 1; s < RD_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    if (load_mem) begin
      for (int w = 0; w < 16; w++) dmem[w] <= init_w[w];
    end else if (mem_wr) begin
      wr_count <= wr_count + 1;
`ifdef MEMACC_BYTE_EN_EN
      for (int b = 0; b < 8; b++)
        if (mem_be[b]) dmem[mem_addr[6:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
`else
      dmem[mem_addr[6:3]] <= mem_wdata;
`endif
    end
  end

  // reference model: flat byte array
  logic [7:0] ref_bytes [0:127];
  int exp_wr = 0;

  function automatic void ref_access(input logic we, input logic [2:0] f3, input int addr,
                                     input logic [63:0] wdata, output logic err,
                                     output logic [63:0] data);
    int n;
    n = 1 << f3[1:0];
    data = 64'd0;
    err = (f3 == 3'd7) || (we && f3[2]) || ((addr % n) != 0);
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) ref_bytes[addr + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) data = data | (64'(ref_bytes[addr + i]) << (8 * i));
      if (!f3[2] && n < 8 && data[8*n-1]) data = data | ({64{1'b1}} << (8 * n));
    end
  endfunction

  function automatic int exp_lat(input logic we, input logic [2:0] f3, input logic err);
    if (err) return 1;
    if (!we) return 2 + RD_LAT;
    if (f3[1:0] == 2'b11) return 2;
`ifdef MEMACC_BYTE_EN_EN
    return 2;
`else
    return 3 + RD_LAT;
`endif
  endfunction

  // scoreboard
  int n_checks = 0;
  int n_pass = 0;
  logic [64:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic [64:0] mon_e;
  int          mon_c;
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("rsp_err", {63'd0, rsp_err}, {63'd0, mon_e[64]});
        check("rsp_rdata", rsp_rdata, mon_e[63:0]);
        check("rsp_cycle", 64'(cyc), 64'(mon_c));
      end
    end
  end

  // driver
  task automatic do_req(input logic we, input logic [2:0] f3, input int addr,
                        input logic [63:0] wdata, input bit keep, output int acc_cyc);
    int t;
    logic err;
    logic [63:0] d;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = 64'(addr);
    req_wdata = wdata;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    acc_cyc = cyc;
    if (!req_ready) begin
      check("accept_timeout", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b0;
      return;
    end
    ref_access(we, f3, addr, wdata, err, d);
    exp_q.push_back({err, d});
    exp_cyc_q.push_back(cyc + exp_lat(we, f3, err));
    if (we && !err) exp_wr++;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 100);
    if (!rsp_valid) check("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
    if (!keep) req_valid = 1'b0;
  endtask

  int a0, a1, a2, t;

  initial begin
    for (int w = 0; w < 16; w++) init_w[w] = {$urandom, $urandom};
    init_w[2] = 64'h8877_6655_4433_2211;
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 8; b++) ref_bytes[8*w + b] = init_w[w][8*b +: 8];
    load_mem = 1'b1;
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_mem_wr", {63'd0, mem_wr}, 64'd0);
    check("reset_rsp_rdata", rsp_rdata, 64'd0);
    check("reset_mem_addr", mem_addr, 64'd0);
    check("reset_mem_wdata", mem_wdata, 64'd0);
    reset = 1'b0;

    // directed plan cases on the word at 0x10
    do_req(1'b0, 3'b000, 'h17, 64'd0, 1'b0, a0);
    do_req(1'b0, 3'b100, 'h17, 64'd0, 1'b0, a0);
    do_req(1'b0, 3'b010, 'h14, 64'd0, 1'b0, a0);
    do_req(1'b0, 3'b110, 'h14, 64'd0, 1'b0, a0);
    do_req(1'b0, 3'b011, 'h10, 64'd0, 1'b0, a0);
    do_req(1'b1, 3'b001, 'h12, 64'h1234_ABCD, 1'b0, a0);
    do_req(1'b0, 3'b011, 'h10, 64'd0, 1'b0, a0);
    do_req(1'b0, 3'b010, 'h13, 64'd0, 1'b0, a0);
    do_req(1'b1, 3'b011, 'h14, 64'hDEAD_BEEF_0000_0001, 1'b0, a0);
    do_req(1'b1, 3'b111, 'h20, 64'd5, 1'b0, a0);
    do_req(1'b1, 3'b100, 'h20, 64'd5, 1'b0, a0);

    // sb aborted by reset while the read is outstanding
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b000;
    req_addr  = 64'h15;
    req_wdata = 64'hEE;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_mem_wr", {63'd0, mem_wr}, 64'd0);
    check("abort_req_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 3'b011, 'h10, 64'd0, 1'b0, a0);

    // req_valid held high: three back-to-back ld, then sd followed by lw
    do_req(1'b0, 3'b011, 'h10, 64'd0, 1'b1, a0);
    do_req(1'b0, 3'b011, 'h10, 64'd0, 1'b1, a1);
    do_req(1'b0, 3'b011, 'h10, 64'd0, 1'b0, a2);
    check("b2b_gap1", 64'(a1 - a0), 64'(3 + RD_LAT));
    check("b2b_gap2", 64'(a2 - a1), 64'(3 + RD_LAT));
    do_req(1'b1, 3'b011, 'h18, {$urandom, $urandom}, 1'b1, a0);
    do_req(1'b0, 3'b010, 'h18, 64'd0, 1'b0, a1);
    check("sd_hold_gap", 64'(a1 - a0), 64'd3);

    // random traffic
    for (int k = 0; k < 120; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
             {$urandom, $urandom}, 1'b0, a0);
    end

    repeat (5) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("write_count", 64'(wr_count), 64'(exp_wr));
    for (int w = 0; w < 16; w++) begin
      logic [63:0] word;
      for (int b = 0; b < 8; b++) word[8*b +: 8] = ref_bytes[8*w + b];
      check("final_mem", dmem[w], word);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
